// File: rtl/reaction_delay_countdown.sv
// rtl/reaction_delay_countdown.sv - BCD down-counter timing the foreperiod before the reaction stimulus
module reaction_delay_countdown #(
    parameter int          DIGITS    = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          MIN_MSD   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  use_fixed,
    input  logic [4*DIGITS-1:0]   preset_bcd,
    input  logic                  ack,
    input  logic                  abort,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  stim,
    output logic                  expired,
    output logic                  false_start
);

    localparam int          W    = 4 * DIGITS;
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [3:0]  MSD  = 4'(MIN_MSD);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   bcd_q, bcd_d;
    logic           expired_q, expired_d;
    logic           false_start_q, false_start_d;
    logic [15:0]    lfsr_q, lfsr_d;

    logic [W-1:0]   rand_preset;
    logic [W-1:0]   fixed_preset;
    logic [W-1:0]   bcd_dec;
    logic           bcd_zero;

    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Map raw nibbles to legal BCD digits; random presets fold 10..15 down to 4..9.
    always_comb begin
        logic [3:0] nib;
        rand_preset  = '0;
        fixed_preset = '0;
        nib          = '0;
        for (int k = 0; k < DIGITS; k++) begin
            nib = lfsr_q[4*k +: 4];
            rand_preset[4*k +: 4] = (nib > 4'd9) ? nib - 4'd6 : nib;
            nib = preset_bcd[4*k +: 4];
            fixed_preset[4*k +: 4] = (nib > 4'd9) ? 4'd9 : nib;
        end
        if (rand_preset[W-1 -: 4] < MSD) begin
            rand_preset[W-1 -: 4] = MSD;
        end
    end

    always_comb begin
        logic borrow;
        bcd_dec = bcd_q;
        borrow  = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (borrow) begin
                if (bcd_q[4*k +: 4] == 4'd0) begin
                    bcd_dec[4*k +: 4] = 4'd9;
                end else begin
                    bcd_dec[4*k +: 4] = bcd_q[4*k +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    assign bcd_zero = (bcd_q == '0);

    always_comb begin
        state_d       = state_q;
        bcd_d         = bcd_q;
        expired_d     = 1'b0;
        false_start_d = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            bcd_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_RUN;
                        bcd_d   = use_fixed ? fixed_preset : rand_preset;
                    end
                end
                ST_RUN: begin
                    if (ack) begin
                        state_d       = ST_IDLE;
                        false_start_d = 1'b1;
                    end else if (tick) begin
                        if (bcd_zero) begin
                            state_d   = ST_EXPIRED;
                            expired_d = 1'b1;
                        end else begin
                            bcd_d = bcd_dec;
                        end
                    end
                end
                ST_EXPIRED: begin
                    if (ack) begin
                        state_d = ST_IDLE;
                        bcd_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    bcd_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bcd_q         <= '0;
            expired_q     <= 1'b0;
            false_start_q <= 1'b0;
            lfsr_q        <= SEED;
        end else begin
            state_q       <= state_d;
            bcd_q         <= bcd_d;
            expired_q     <= expired_d;
            false_start_q <= false_start_d;
            lfsr_q        <= lfsr_d;
        end
    end

    assign bcd         = bcd_q;
    assign busy        = (state_q == ST_RUN);
    assign stim        = (state_q == ST_EXPIRED);
    assign expired     = expired_q;
    assign false_start = false_start_q;

endmodule

// File: tb/tb_reaction_delay_countdown.sv
// tb/tb_reaction_delay_countdown.sv - randomized bench with behavioural countdown model
module tb_reaction_delay_countdown;

    localparam int          MIN_MSD = 1;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick, start, use_fixed, ack, abort;
    logic [11:0] preset_bcd;
    logic [11:0] bcd;
    logic        busy, stim, expired, false_start;

    int n_pass = 0;
    int n_total = 0;

    int          m_state;   // 0 idle, 1 counting, 2 stimulus shown
    int          m_count;
    bit          m_exp, m_fs;
    logic [15:0] m_lfsr;

    reaction_delay_countdown #(.DIGITS(3), .LFSR_SEED(SEED), .MIN_MSD(MIN_MSD)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .use_fixed(use_fixed),
        .preset_bcd(preset_bcd), .ack(ack), .abort(abort), .bcd(bcd), .busy(busy),
        .stim(stim), .expired(expired), .false_start(false_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int preset_val(input bit fixed, input logic [11:0] p, input logic [15:0] l);
        int v = 0;
        int w = 1;
        for (int k = 0; k < 3; k++) begin
            int n;
            if (fixed) begin
                n = int'(p[4*k +: 4]);
                if (n > 9) n = 9;
            end else begin
                n = int'(l[4*k +: 4]);
                if (n > 9) n = n - 6;
                if (k == 2 && n < MIN_MSD) n = MIN_MSD;
            end
            v += n * w;
            w *= 10;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_count = 0; m_exp = 0; m_fs = 0; m_lfsr = SEED;
    endtask

    task automatic model_clock();
        m_exp = 0;
        m_fs  = 0;
        if (abort) begin
            m_state = 0; m_count = 0;
        end else if (m_state == 0) begin
            if (start) begin
                m_count = preset_val(use_fixed, preset_bcd, m_lfsr);
                m_state = 1;
            end
        end else if (m_state == 1) begin
            if (ack) begin
                m_state = 0; m_fs = 1;
            end else if (tick) begin
                if (m_count == 0) begin
                    m_state = 2; m_exp = 1;
                end else m_count--;
            end
        end else if (ack) begin
            m_state = 0; m_count = 0;
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    task automatic compare_all();
        chk("bcd", 32'(bcd), 32'(to_bcd(m_count)));
        chk("busy", 32'(busy), 32'(m_state == 1));
        chk("stim", 32'(stim), 32'(m_state == 2));
        chk("expired", 32'(expired), 32'(m_exp));
        chk("false_start", 32'(false_start), 32'(m_fs));
        chk("busy_stim_exclusive", 32'(busy & stim), 32'd0);
    endtask

    // Drive one cycle of inputs, clock it, advance the model and compare just after the edge.
    task automatic step(input bit ab, input bit ak, input bit tk, input bit st,
                        input bit uf, input logic [11:0] pr);
        abort = ab; ack = ak; tick = tk; start = st; use_fixed = uf; preset_bcd = pr;
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 12'h000);
    endtask

    logic [11:0] exp_list [5] = '{12'h102, 12'h101, 12'h100, 12'h099, 12'h098};

    initial begin
        reset = 1'b1;
        {tick, start, use_fixed, ack, abort} = '0;
        preset_bcd = '0;
        model_reset();
        #3;
        chk("reset_bcd", 32'(bcd), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_stim", 32'(stim), 32'h0);
        chk("reset_expired", 32'(expired), 32'h0);
        chk("reset_false_start", 32'(false_start), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Random preset from the seed: nibbles 1, E->8, C->6.
        step(0, 0, 0, 1, 0, 12'h000);
        chk("seed_preset", 32'(bcd), 32'h681);
        chk("seed_busy", 32'(busy), 32'h1);
        step(1, 0, 1, 0, 0, 12'h000);
        chk("abort_tick_bcd", 32'(bcd), 32'h0);
        chk("abort_tick_busy", 32'(busy), 32'h0);

        // Asynchronous reset in the middle of a countdown.
        step(0, 0, 0, 1, 1, 12'h257);
        step(0, 0, 1, 0, 0, 12'h000);
        step(0, 0, 1, 0, 0, 12'h000);
        chk("pre_reset_bcd", 32'(bcd), 32'h255);
        #3 reset = 1'b1;
        #1;
        model_reset();
        chk("async_reset_bcd", 32'(bcd), 32'h0);
        chk("async_reset_busy", 32'(busy), 32'h0);
        #1 reset = 1'b0;
        step(0, 0, 0, 1, 0, 12'h000);
        chk("reload_after_reset", 32'(bcd), 32'h681);
        step(1, 0, 0, 0, 0, 12'h000);

        // Borrow chain through 100 -> 099, ticks every other clock.
        step(0, 0, 0, 1, 1, 12'h103);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 0, 12'h000);
            chk("borrow_bcd", 32'(bcd), 32'(exp_list[i]));
            idle_step();
        end
        step(1, 0, 0, 0, 0, 12'h000);

        // Short preset expiring on the third tick.
        step(0, 0, 0, 1, 1, 12'h002);
        step(0, 0, 1, 0, 0, 12'h000);
        step(0, 0, 1, 0, 0, 12'h000);
        chk("short_zero", 32'(bcd), 32'h000);
        step(0, 0, 1, 0, 0, 12'h000);
        chk("short_expired", 32'(expired), 32'h1);
        chk("short_stim", 32'(stim), 32'h1);
        idle_step();
        chk("expired_one_clk", 32'(expired), 32'h0);
        step(0, 1, 0, 0, 0, 12'h000);
        chk("ack_clears_stim", 32'(stim), 32'h0);

        // False start after ten ticks, then back-to-back restart.
        step(0, 0, 0, 1, 1, 12'h050);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0, 12'h000);
        step(0, 1, 0, 0, 0, 12'h000);
        chk("false_start_pulse", 32'(false_start), 32'h1);
        chk("false_start_bcd", 32'(bcd), 32'h040);
        chk("false_start_busy", 32'(busy), 32'h0);
        step(0, 0, 0, 1, 1, 12'h321);
        chk("false_start_one_clk", 32'(false_start), 32'h0);
        chk("back_to_back_busy", 32'(busy), 32'h1);
        step(1, 0, 0, 0, 0, 12'h000);

        // Illegal nibbles clamp to 9; an all-zero preset expires on the first tick.
        step(0, 0, 0, 1, 1, 12'hFA0);
        chk("clamp_preset", 32'(bcd), 32'h990);
        step(1, 0, 0, 0, 0, 12'h000);
        step(0, 0, 0, 1, 1, 12'h000);
        step(0, 0, 1, 0, 0, 12'h000);
        chk("zero_preset_expired", 32'(expired), 32'h1);
        step(0, 1, 0, 0, 0, 12'h000);

        for (int i = 0; i < 4000; i++) begin
            bit ab, ak, tk, st;
            ab = ($urandom_range(0, 63) == 0);
            ak = ($urandom_range(0, 19) == 0);
            tk = ($urandom_range(0, 2) == 0);
            st = !ak && !tk && ($urandom_range(0, 5) == 0);
            step(ab, ak, tk, st, 1'($urandom_range(0, 1)), 12'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
